// File: rtl/coreaxi4sram_slvif_buf.sv
// -----------------------------------------------------------------------------
// coreaxi4sram_slvif_buf
// Buffered AXI4 slave interface for the AXI4 SRAM core. It sits between the
// external AXI4 slave port and main control:
//   - AW / AR : ADDR_FIFO_DEPTH-entry address FIFOs with registered heads
//   - W  / R  : 2-entry skid-buffer register slices
//   - B       : 1-entry register slice
// Every output is a flop, so there is no combinational path from the AXI
// master to main control. The one exception is b_ready_mc, which also looks
// at BREADY_S.
//
// Ports:
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   AW*_S / W*_S / B*_S      AXI4 write channels (master side)
//   AR*_S / R*_S             AXI4 read channels (master side)
//   aw_*_mc, ar_*_mc         address FIFO heads to main control (valid/ready)
//   aw_err_mc, ar_err_mc     illegal-burst flag that travels with each head
//   w_*_mc                   write data to main control (valid/ready)
//   b_*_mc, r_*_mc           write response / read data from main control
//
// Optional feature (macro COREAXI4SRAM_SLVIF_BURSTCHK_EN):
//   When the macro is defined, each address FIFO entry carries one extra bit.
//   The bit flags a reserved burst type, or a WRAP burst whose length is not
//   2/4/8/16 beats. When the macro is undefined, aw_err_mc and ar_err_mc are
//   tied to 0 and the extra bit is not stored.
// -----------------------------------------------------------------------------

// Address FIFO. The head is held in a register so that the payload toward
// main control comes straight from flops. The input ready is also a flop.
module coreaxi4sram_slvif_buf_afifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic          r_valid;
  logic [W-1:0]  r_head;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [W-1:0]  w_head_next;

  assign w_push  = i_valid && r_ready;
  assign w_pop   = r_valid && i_ready;
  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_head;

  // Next count, next read pointer and the next head value.
  always_comb begin
    w_count_next  = r_count;
    w_rd_ptr_next = r_rd_ptr;
    w_head_next   = r_head;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1'b1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1'b1);
    end else begin
      w_count_next = r_count;
    end
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + PW'(1'b1);
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end
    // If the slot that becomes the head is written on this same edge, the
    // memory still holds the old value, so take the incoming word directly.
    if (w_push && ((r_count == {CW{1'b0}}) || ((r_count == CW'(1'b1)) && w_pop))) begin
      w_head_next = i_data;
    end else if (w_count_next != {CW{1'b0}}) begin
      w_head_next = r_mem[w_rd_ptr_next];
    end else begin
      w_head_next = r_head;
    end
  end

  // Storage array. The pointers are reset, so the contents need no reset.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy, registered ready/valid and the head register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_head   <= {W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1'b1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_ready  <= (w_count_next < DEPTH_C);
      r_valid  <= (w_count_next != {CW{1'b0}});
      r_head   <= w_head_next;
    end
  end
endmodule

// Two-entry skid buffer. Data leaves from the main register. The skid
// register catches the one beat that is accepted while main is stalled.
module coreaxi4sram_slvif_buf_skid #(
  parameter int W = 8
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_ready;
  logic         r_main_v;
  logic         r_skid_v;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_valid && r_ready;
  assign w_pop   = r_main_v && i_ready;
  assign o_ready = r_ready;
  assign o_valid = r_main_v;
  assign o_data  = r_main;

  // Main and skid register update. Ready is low exactly while skid is full.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_ready  <= 1'b0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= {W{1'b0}};
      r_skid   <= {W{1'b0}};
    end else if (w_pop || !r_main_v) begin
      // Main is free this cycle. The skid beat is older than any new input.
      // Ready was low while skid was full, so no push can happen alongside it.
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else if (w_push) begin
        r_main   <= i_data;
        r_main_v <= 1'b1;
      end else begin
        r_main_v <= 1'b0;
      end
      r_ready <= 1'b1;
    end else if (w_push) begin
      r_skid   <= i_data;
      r_skid_v <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= !r_skid_v;
    end
  end
endmodule

module coreaxi4sram_slvif_buf #(
  parameter int AXI4_DWIDTH     = 64,
  parameter int AXI4_AWIDTH     = 32,
  parameter int AXI4_IDWIDTH    = 4,
  parameter int ADDR_FIFO_DEPTH = 2,
  parameter int AXI4_IFTYPE_WR  = 1,
  parameter int AXI4_IFTYPE_RD  = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [AXI4_IDWIDTH-1:0]   AWID_S,
  input  logic [AXI4_AWIDTH-1:0]    AWADDR_S,
  input  logic [7:0]                AWLEN_S,
  input  logic [2:0]                AWSIZE_S,
  input  logic [1:0]                AWBURST_S,
  input  logic                      AWVALID_S,
  output logic                      AWREADY_S,
  input  logic [AXI4_DWIDTH-1:0]    WDATA_S,
  input  logic [AXI4_DWIDTH/8-1:0]  WSTRB_S,
  input  logic                      WLAST_S,
  input  logic                      WVALID_S,
  output logic                      WREADY_S,
  output logic [AXI4_IDWIDTH-1:0]   BID_S,
  output logic [1:0]                BRESP_S,
  output logic                      BVALID_S,
  input  logic                      BREADY_S,
  input  logic [AXI4_IDWIDTH-1:0]   ARID_S,
  input  logic [AXI4_AWIDTH-1:0]    ARADDR_S,
  input  logic [7:0]                ARLEN_S,
  input  logic [2:0]                ARSIZE_S,
  input  logic [1:0]                ARBURST_S,
  input  logic                      ARVALID_S,
  output logic                      ARREADY_S,
  output logic [AXI4_IDWIDTH-1:0]   RID_S,
  output logic [AXI4_DWIDTH-1:0]    RDATA_S,
  output logic [1:0]                RRESP_S,
  output logic                      RLAST_S,
  output logic                      RVALID_S,
  input  logic                      RREADY_S,
  output logic [AXI4_IDWIDTH-1:0]   aw_id_mc,
  output logic [AXI4_AWIDTH-1:0]    aw_addr_mc,
  output logic [7:0]                aw_len_mc,
  output logic [2:0]                aw_size_mc,
  output logic [1:0]                aw_burst_mc,
  output logic                      aw_valid_mc,
  input  logic                      aw_ready_mc,
  output logic                      aw_err_mc,
  output logic [AXI4_DWIDTH-1:0]    w_data_mc,
  output logic [AXI4_DWIDTH/8-1:0]  w_strb_mc,
  output logic                      w_last_mc,
  output logic                      w_valid_mc,
  input  logic                      w_ready_mc,
  output logic [AXI4_IDWIDTH-1:0]   ar_id_mc,
  output logic [AXI4_AWIDTH-1:0]    ar_addr_mc,
  output logic [7:0]                ar_len_mc,
  output logic [2:0]                ar_size_mc,
  output logic [1:0]                ar_burst_mc,
  output logic                      ar_valid_mc,
  input  logic                      ar_ready_mc,
  output logic                      ar_err_mc,
  input  logic [AXI4_IDWIDTH-1:0]   b_id_mc,
  input  logic [1:0]                b_resp_mc,
  input  logic                      b_valid_mc,
  output logic                      b_ready_mc,
  input  logic [AXI4_IDWIDTH-1:0]   r_id_mc,
  input  logic [AXI4_DWIDTH-1:0]    r_data_mc,
  input  logic [1:0]                r_resp_mc,
  input  logic                      r_last_mc,
  input  logic                      r_valid_mc,
  output logic                      r_ready_mc
);
  localparam int AEW = AXI4_IDWIDTH + AXI4_AWIDTH + 8 + 3 + 2;
  localparam int WEW = AXI4_DWIDTH + AXI4_DWIDTH/8 + 1;
  localparam int REW = AXI4_IDWIDTH + AXI4_DWIDTH + 2 + 1;
`ifdef COREAXI4SRAM_SLVIF_BURSTCHK_EN
  localparam int EW = AEW + 1;

  // Reserved burst type, or a WRAP burst whose length is not 2/4/8/16 beats.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
  endfunction
`else
  localparam int EW = AEW;
`endif

  if (AXI4_IFTYPE_WR != 0) begin : g_wr
    logic [EW-1:0]           w_aw_in;
    logic [EW-1:0]           w_aw_out;
    logic                    r_b_en;
    logic                    r_bvalid;
    logic [AXI4_IDWIDTH-1:0] r_bid;
    logic [1:0]              r_bresp;

`ifdef COREAXI4SRAM_SLVIF_BURSTCHK_EN
    assign w_aw_in   = {burst_err(AWBURST_S, AWLEN_S), AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S};
    assign aw_err_mc = w_aw_out[EW-1];
`else
    assign w_aw_in   = {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S};
    assign aw_err_mc = 1'b0;
`endif
    assign {aw_id_mc, aw_addr_mc, aw_len_mc, aw_size_mc, aw_burst_mc} = w_aw_out[AEW-1:0];

    coreaxi4sram_slvif_buf_afifo #(.W(EW), .DEPTH(ADDR_FIFO_DEPTH)) u_aw_fifo (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .i_valid(AWVALID_S), .o_ready(AWREADY_S), .i_data(w_aw_in),
      .o_valid(aw_valid_mc), .i_ready(aw_ready_mc), .o_data(w_aw_out)
    );

    coreaxi4sram_slvif_buf_skid #(.W(WEW)) u_w_slice (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .i_valid(WVALID_S), .o_ready(WREADY_S), .i_data({WDATA_S, WSTRB_S, WLAST_S}),
      .o_valid(w_valid_mc), .i_ready(w_ready_mc), .o_data({w_data_mc, w_strb_mc, w_last_mc})
    );

    // r_b_en holds b_ready_mc low during reset and until the first edge after it.
    assign b_ready_mc = r_b_en && (!r_bvalid || BREADY_S);
    assign BVALID_S   = r_bvalid;
    assign BID_S      = r_bid;
    assign BRESP_S    = r_bresp;

    // Single-entry write response register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        r_b_en   <= 1'b0;
        r_bvalid <= 1'b0;
        r_bid    <= {AXI4_IDWIDTH{1'b0}};
        r_bresp  <= 2'b00;
      end else begin
        r_b_en <= 1'b1;
        if (b_valid_mc && b_ready_mc) begin
          r_bvalid <= 1'b1;
          r_bid    <= b_id_mc;
          r_bresp  <= b_resp_mc;
        end else if (BREADY_S) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end else begin : g_no_wr
    assign AWREADY_S   = 1'b0;
    assign aw_id_mc    = {AXI4_IDWIDTH{1'b0}};
    assign aw_addr_mc  = {AXI4_AWIDTH{1'b0}};
    assign aw_len_mc   = 8'd0;
    assign aw_size_mc  = 3'd0;
    assign aw_burst_mc = 2'd0;
    assign aw_valid_mc = 1'b0;
    assign aw_err_mc   = 1'b0;
    assign WREADY_S    = 1'b0;
    assign w_data_mc   = {AXI4_DWIDTH{1'b0}};
    assign w_strb_mc   = {(AXI4_DWIDTH/8){1'b0}};
    assign w_last_mc   = 1'b0;
    assign w_valid_mc  = 1'b0;
    assign BID_S       = {AXI4_IDWIDTH{1'b0}};
    assign BRESP_S     = 2'b00;
    assign BVALID_S    = 1'b0;
    assign b_ready_mc  = 1'b1;
  end

  if (AXI4_IFTYPE_RD != 0) begin : g_rd
    logic [EW-1:0] w_ar_in;
    logic [EW-1:0] w_ar_out;

`ifdef COREAXI4SRAM_SLVIF_BURSTCHK_EN
    assign w_ar_in   = {burst_err(ARBURST_S, ARLEN_S), ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S};
    assign ar_err_mc = w_ar_out[EW-1];
`else
    assign w_ar_in   = {ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S};
    assign ar_err_mc = 1'b0;
`endif
    assign {ar_id_mc, ar_addr_mc, ar_len_mc, ar_size_mc, ar_burst_mc} = w_ar_out[AEW-1:0];

    coreaxi4sram_slvif_buf_afifo #(.W(EW), .DEPTH(ADDR_FIFO_DEPTH)) u_ar_fifo (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .i_valid(ARVALID_S), .o_ready(ARREADY_S), .i_data(w_ar_in),
      .o_valid(ar_valid_mc), .i_ready(ar_ready_mc), .o_data(w_ar_out)
    );

    coreaxi4sram_slvif_buf_skid #(.W(REW)) u_r_slice (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .i_valid(r_valid_mc), .o_ready(r_ready_mc), .i_data({r_id_mc, r_data_mc, r_resp_mc, r_last_mc}),
      .o_valid(RVALID_S), .i_ready(RREADY_S), .o_data({RID_S, RDATA_S, RRESP_S, RLAST_S})
    );
  end else begin : g_no_rd
    assign ARREADY_S   = 1'b0;
    assign ar_id_mc    = {AXI4_IDWIDTH{1'b0}};
    assign ar_addr_mc  = {AXI4_AWIDTH{1'b0}};
    assign ar_len_mc   = 8'd0;
    assign ar_size_mc  = 3'd0;
    assign ar_burst_mc = 2'd0;
    assign ar_valid_mc = 1'b0;
    assign ar_err_mc   = 1'b0;
    assign RID_S       = {AXI4_IDWIDTH{1'b0}};
    assign RDATA_S     = {AXI4_DWIDTH{1'b0}};
    assign RRESP_S     = 2'b00;
    assign RLAST_S     = 1'b0;
    assign RVALID_S    = 1'b0;
    assign r_ready_mc  = 1'b1;
  end
endmodule

// File: tb/tb_coreaxi4sram_slvif_buf.sv
// Self-checking bench for coreaxi4sram_slvif_buf (default parameters).
// Inputs are driven 1 ns after each rising edge. The W and R stream monitors
// sample on the falling edge and compare each beat against queued expectations.
module tb_coreaxi4sram_slvif_buf;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWID_S, ARID_S, BID_S, RID_S;
  logic [31:0] AWADDR_S, ARADDR_S;
  logic [7:0]  AWLEN_S, ARLEN_S;
  logic [2:0]  AWSIZE_S, ARSIZE_S;
  logic [1:0]  AWBURST_S, ARBURST_S, BRESP_S, RRESP_S;
  logic        AWVALID_S, AWREADY_S, ARVALID_S, ARREADY_S;
  logic [63:0] WDATA_S, RDATA_S;
  logic [7:0]  WSTRB_S;
  logic        WLAST_S, WVALID_S, WREADY_S, BVALID_S, BREADY_S;
  logic        RLAST_S, RVALID_S, RREADY_S;
  logic [3:0]  aw_id_mc, ar_id_mc, b_id_mc, r_id_mc;
  logic [31:0] aw_addr_mc, ar_addr_mc;
  logic [7:0]  aw_len_mc, ar_len_mc;
  logic [2:0]  aw_size_mc, ar_size_mc;
  logic [1:0]  aw_burst_mc, ar_burst_mc, b_resp_mc, r_resp_mc;
  logic        aw_valid_mc, aw_ready_mc, aw_err_mc, ar_valid_mc, ar_ready_mc, ar_err_mc;
  logic [63:0] w_data_mc, r_data_mc;
  logic [7:0]  w_strb_mc;
  logic        w_last_mc, w_valid_mc, w_ready_mc;
  logic        b_valid_mc, b_ready_mc, r_last_mc, r_valid_mc, r_ready_mc;

  int n_total = 0;
  int n_pass  = 0;

  logic [72:0] wq[$];
  logic [70:0] rq[$];
  logic [72:0] wexp;
  logic [70:0] rexp;

  typedef struct {
    logic        avalid;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [7:0]  len;
    logic        mc_ready;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_addr;
    logic        e_illegal;
  } addr_vec_t;
  addr_vec_t tbl [10];

  coreaxi4sram_slvif_buf dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .aw_id_mc(aw_id_mc), .aw_addr_mc(aw_addr_mc), .aw_len_mc(aw_len_mc), .aw_size_mc(aw_size_mc),
    .aw_burst_mc(aw_burst_mc), .aw_valid_mc(aw_valid_mc), .aw_ready_mc(aw_ready_mc), .aw_err_mc(aw_err_mc),
    .w_data_mc(w_data_mc), .w_strb_mc(w_strb_mc), .w_last_mc(w_last_mc),
    .w_valid_mc(w_valid_mc), .w_ready_mc(w_ready_mc),
    .ar_id_mc(ar_id_mc), .ar_addr_mc(ar_addr_mc), .ar_len_mc(ar_len_mc), .ar_size_mc(ar_size_mc),
    .ar_burst_mc(ar_burst_mc), .ar_valid_mc(ar_valid_mc), .ar_ready_mc(ar_ready_mc), .ar_err_mc(ar_err_mc),
    .b_id_mc(b_id_mc), .b_resp_mc(b_resp_mc), .b_valid_mc(b_valid_mc), .b_ready_mc(b_ready_mc),
    .r_id_mc(r_id_mc), .r_data_mc(r_data_mc), .r_resp_mc(r_resp_mc), .r_last_mc(r_last_mc),
    .r_valid_mc(r_valid_mc), .r_ready_mc(r_ready_mc)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [72:0] wbeat(input int k, input logic last);
    logic [63:0] d;
    logic [7:0]  s;
    d = {32'hC0DE0000 | 32'(k), 32'h00001000 + 32'(k)};
    s = 8'hFF ^ 8'(k);
    return {d, s, last};
  endfunction

  // W stream monitor: a handshake completes on the next rising edge.
  always @(negedge ACLK) begin
    if (ARESETN && w_valid_mc && w_ready_mc) begin
      if (wq.size() == 0) begin
        n_total++;
        $display("FAIL w_extra_beat: got %0h expected none", w_data_mc);
      end else begin
        wexp = wq.pop_front();
        check("w_beat", {w_data_mc, w_strb_mc, w_last_mc}, wexp);
      end
    end
  end

  // R stream monitor.
  always @(negedge ACLK) begin
    if (ARESETN && RVALID_S && RREADY_S) begin
      if (rq.size() == 0) begin
        n_total++;
        $display("FAIL r_extra_beat: got %0h expected none", RDATA_S);
      end else begin
        rexp = rq.pop_front();
        check("r_beat", {RID_S, RDATA_S, RRESP_S, RLAST_S}, rexp);
      end
    end
  end

  initial begin
    int k;
    int cyc;
    int nlow;
    logic exp_err;

    // Address FIFO vectors, applied identically to AW and AR. e_illegal marks
    // heads whose burst is illegal (reserved, or WRAP with a bad length).
    tbl[0] = '{1'b1, 32'h100, 2'b01, 8'd5, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0};
    tbl[1] = '{1'b1, 32'h200, 2'b10, 8'd5, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    tbl[2] = '{1'b1, 32'h300, 2'b10, 8'd7, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0};
    tbl[3] = '{1'b0, 32'h000, 2'b00, 8'd0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1};
    tbl[4] = '{1'b1, 32'h300, 2'b10, 8'd7, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0};
    tbl[5] = '{1'b1, 32'h400, 2'b11, 8'd0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0};
    tbl[6] = '{1'b0, 32'h000, 2'b00, 8'd0, 1'b1, 1'b1, 1'b1, 32'h400, 1'b1};
    tbl[7] = '{1'b0, 32'h000, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0};
    tbl[8] = '{1'b1, 32'h500, 2'b01, 8'd5, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0};
    tbl[9] = '{1'b0, 32'h000, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, 32'h000, 1'b0};

    ARESETN = 1'b0;
    AWID_S = 4'd0; AWADDR_S = 32'd0; AWLEN_S = 8'd0; AWSIZE_S = 3'd3; AWBURST_S = 2'b01; AWVALID_S = 1'b0;
    ARID_S = 4'd0; ARADDR_S = 32'd0; ARLEN_S = 8'd0; ARSIZE_S = 3'd3; ARBURST_S = 2'b01; ARVALID_S = 1'b0;
    WDATA_S = 64'd0; WSTRB_S = 8'd0; WLAST_S = 1'b0; WVALID_S = 1'b0;
    BREADY_S = 1'b0; RREADY_S = 1'b0;
    aw_ready_mc = 1'b0; ar_ready_mc = 1'b0; w_ready_mc = 1'b0;
    b_id_mc = 4'd0; b_resp_mc = 2'b00; b_valid_mc = 1'b0;
    r_id_mc = 4'd0; r_data_mc = 64'd0; r_resp_mc = 2'b00; r_last_mc = 1'b0; r_valid_mc = 1'b0;

    // Reset state
    step(); step(); step();
    check("rst_awready", AWREADY_S, 1'b0);
    check("rst_arready", ARREADY_S, 1'b0);
    check("rst_wready", WREADY_S, 1'b0);
    check("rst_r_ready_mc", r_ready_mc, 1'b0);
    check("rst_b_ready_mc", b_ready_mc, 1'b0);
    check("rst_aw_valid", aw_valid_mc, 1'b0);
    check("rst_rvalid", RVALID_S, 1'b0);
    check("rst_bvalid", BVALID_S, 1'b0);
    ARESETN = 1'b1;
    #1;
    check("rel_awready_pre_edge", AWREADY_S, 1'b0);
    step();
    check("rel_awready", AWREADY_S, 1'b1);
    check("rel_arready", ARREADY_S, 1'b1);
    check("rel_wready", WREADY_S, 1'b1);
    check("rel_r_ready_mc", r_ready_mc, 1'b1);
    check("rel_b_ready_mc", b_ready_mc, 1'b1);

    // Address FIFO table
    for (int i = 0; i < 10; i++) begin
      AWVALID_S = tbl[i].avalid; AWADDR_S = tbl[i].addr; AWBURST_S = tbl[i].burst;
      AWLEN_S = tbl[i].len; AWID_S = tbl[i].addr[11:8]; aw_ready_mc = tbl[i].mc_ready;
      ARVALID_S = tbl[i].avalid; ARADDR_S = tbl[i].addr; ARBURST_S = tbl[i].burst;
      ARLEN_S = tbl[i].len; ARID_S = tbl[i].addr[11:8]; ar_ready_mc = tbl[i].mc_ready;
      step();
`ifdef COREAXI4SRAM_SLVIF_BURSTCHK_EN
      exp_err = tbl[i].e_illegal;
`else
      exp_err = 1'b0;
`endif
      check("awready", AWREADY_S, tbl[i].e_ready);
      check("aw_valid", aw_valid_mc, tbl[i].e_valid);
      check("arready", ARREADY_S, tbl[i].e_ready);
      check("ar_valid", ar_valid_mc, tbl[i].e_valid);
      if (tbl[i].e_valid) begin
        check("aw_addr", aw_addr_mc, tbl[i].e_addr);
        check("aw_id", aw_id_mc, tbl[i].e_addr[11:8]);
        check("aw_err", aw_err_mc, exp_err);
        check("ar_addr", ar_addr_mc, tbl[i].e_addr);
        check("ar_err", ar_err_mc, exp_err);
      end
    end
    AWVALID_S = 1'b0; ARVALID_S = 1'b0; aw_ready_mc = 1'b0; ar_ready_mc = 1'b0;

    // W: 16 beats while w_ready_mc toggles 1,0,1,0...
    k = 0; cyc = 0; nlow = 0;
    while ((k < 16 || wq.size() != 0) && cyc < 200) begin
      w_ready_mc = (cyc % 2 == 0);
      if (k < 16) begin
        WVALID_S = 1'b1;
        {WDATA_S, WSTRB_S, WLAST_S} = wbeat(k, k == 15);
        if (WREADY_S) wq.push_back(wbeat(k, k == 15));
        else nlow++;
      end else begin
        WVALID_S = 1'b0;
      end
      step();
      if (WVALID_S && wq.size() != 0 && k < 16 && wq[wq.size()-1] == wbeat(k, k == 15)) k++;
      cyc++;
    end
    WVALID_S = 1'b0;
    check("w_toggle_drained", 32'(wq.size()), 32'd0);
    check("w_toggle_all_sent", 32'(k), 32'd16);
    check("w_backpressure_seen", (nlow > 0), 1'b1);

    // W: sustained one beat per cycle with main control always ready
    w_ready_mc = 1'b1; k = 0; cyc = 0; nlow = 0;
    while (k < 8 && cyc < 50) begin
      WVALID_S = 1'b1;
      {WDATA_S, WSTRB_S, WLAST_S} = wbeat(k + 16, k == 7);
      if (WREADY_S) begin
        wq.push_back(wbeat(k + 16, k == 7));
        k++;
      end else begin
        nlow++;
      end
      step();
      cyc++;
    end
    WVALID_S = 1'b0;
    check("w_full_rate_stalls", 32'(nlow), 32'd0);
    check("w_full_rate_cycles", 32'(cyc), 32'd8);
    step(); step();
    check("w_full_rate_drained", 32'(wq.size()), 32'd0);
    w_ready_mc = 1'b0;

    // R: 4 beats, RREADY_S low for the first 3 cycles
    k = 0; cyc = 0;
    while ((k < 4 || rq.size() != 0) && cyc < 100) begin
      RREADY_S = (cyc >= 3);
      if (k < 4) begin
        r_valid_mc = 1'b1; r_id_mc = 4'(k + 8); r_data_mc = {32'hBEEF0000, 32'(k * 7)};
        r_resp_mc = (k == 2) ? 2'b10 : 2'b00; r_last_mc = (k == 3);
        if (r_ready_mc) begin
          rq.push_back({r_id_mc, r_data_mc, r_resp_mc, r_last_mc});
          k++;
        end
      end else begin
        r_valid_mc = 1'b0;
      end
      step();
      if (cyc == 0) begin
        check("r_latency_valid", RVALID_S, 1'b1);
        check("r_latency_data", RDATA_S, {32'hBEEF0000, 32'd0});
      end
      if (cyc == 2) begin
        check("r_stall_valid", RVALID_S, 1'b1);
        check("r_stall_data", RDATA_S, {32'hBEEF0000, 32'd0});
        check("r_stall_ready_mc", r_ready_mc, 1'b0);
      end
      cyc++;
    end
    r_valid_mc = 1'b0; RREADY_S = 1'b0;
    check("r_all_delivered", 32'(rq.size()), 32'd0);
    check("r_all_sent", 32'(k), 32'd4);

    // B slice
    b_valid_mc = 1'b1; b_id_mc = 4'h5; b_resp_mc = 2'b00; BREADY_S = 1'b0;
    #1;
    check("b_ready_idle", b_ready_mc, 1'b1);
    step();
    check("b_valid_set", BVALID_S, 1'b1);
    check("b_id", BID_S, 4'h5);
    b_valid_mc = 1'b0; b_id_mc = 4'h0;
    #1;
    check("b_ready_blocked", b_ready_mc, 1'b0);
    step();
    check("b_valid_held", BVALID_S, 1'b1);
    check("b_id_held", BID_S, 4'h5);
    BREADY_S = 1'b1;
    #1;
    check("b_ready_pass", b_ready_mc, 1'b1);
    step();
    check("b_valid_clear", BVALID_S, 1'b0);
    BREADY_S = 1'b0;

    // Reset mid-operation
    AWVALID_S = 1'b1; AWADDR_S = 32'h600; AWBURST_S = 2'b01; AWLEN_S = 8'd0; aw_ready_mc = 1'b0;
    r_valid_mc = 1'b1; r_data_mc = 64'h1234; r_last_mc = 1'b0; RREADY_S = 1'b0;
    step();
    r_valid_mc = 1'b0;
    AWADDR_S = 32'h700;
    step();
    AWVALID_S = 1'b0;
    check("pre_rst_aw_valid", aw_valid_mc, 1'b1);
    check("pre_rst_rvalid", RVALID_S, 1'b1);
    check("pre_rst_awready", AWREADY_S, 1'b0);
    ARESETN = 1'b0;
    #1;
    check("mid_rst_aw_valid", aw_valid_mc, 1'b0);
    check("mid_rst_rvalid", RVALID_S, 1'b0);
    check("mid_rst_awready", AWREADY_S, 1'b0);
    rq.delete();
    step(); step();
    ARESETN = 1'b1;
    step();
    check("post_rst_aw_valid", aw_valid_mc, 1'b0);
    check("post_rst_awready", AWREADY_S, 1'b1);
    check("post_rst_rvalid", RVALID_S, 1'b0);
    step();
    check("post_rst_aw_still_empty", aw_valid_mc, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
